// File: rtl/dmuldiv_if.sv
// dmuldiv_if
//   E-stage connection between the pipeline and the multiply/divide unit.
//   master : pipeline side (drives hold, op code and operands)
//   slave  : dmuldiv side (returns CE0 result/select, stall and busy)
//   CLMI_RHOLD    pipeline hold (already includes MD_STALL_E)
//   MDOP_E_P      op code from P stage
//   REGA_E_R      rs operand / MT data
//   REGB_E_R      rt operand
//   CE0_RES_E     HI/LO read data for MFHI/MFLO
//   CE0_SEL_E_R   CE0 result select
//   MD_STALL_E    stall request
//   MD_BUSY       iteration in progress
interface dmuldiv_if;
  logic        CLMI_RHOLD;
  logic [3:0]  MDOP_E_P;
  logic [31:0] REGA_E_R;
  logic [31:0] REGB_E_R;
  logic [31:0] CE0_RES_E;
  logic        CE0_SEL_E_R;
  logic        MD_STALL_E;
  logic        MD_BUSY;

  modport master (
    output CLMI_RHOLD, MDOP_E_P, REGA_E_R, REGB_E_R,
    input  CE0_RES_E, CE0_SEL_E_R, MD_STALL_E, MD_BUSY
  );

  modport slave (
    input  CLMI_RHOLD, MDOP_E_P, REGA_E_R, REGB_E_R,
    output CE0_RES_E, CE0_SEL_E_R, MD_STALL_E, MD_BUSY
  );
endinterface

// File: rtl/dmuldiv.sv
// dmuldiv
//   Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers,
//   one operand bit per cycle, feeding the E-stage CE0 result port.
// Ports
//   SYSCLK      core clock, rising edge
//   RESET_D2_R  asynchronous active-high reset
//   bus         dmuldiv_if.slave (hold, op, operands, CE0 result, stall, busy)
// Configuration
//   DMULDIV_EARLY_TERM_EN  when defined, a multiply finishes as soon as the
//                          remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for MULT*/DIV*; MT writes and MF reads serviced here
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign correction and HI/LO write, back to IDLE
module dmuldiv #(
  parameter int MD_ITER = 32,
  parameter int MD_CNTW = 6
) (
  input logic      SYSCLK,
  input logic      RESET_D2_R,
  dmuldiv_if.slave bus
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [MD_CNTW-1:0] CNT_LAST = MD_CNTW'(MD_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         mdop_q, mdop_d;
  logic               ce0_sel_q, ce0_sel_d;
  logic [MD_CNTW-1:0] cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;      // MUL: product; DIV: {remainder, quotient}
  logic [63:0]        mcand_q, mcand_d;  // multiplicand, shifts left so acc stays aligned
  logic [31:0]        opb_q, opb_d;      // MUL: multiplier (shifts right); DIV: divisor
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic        is_md_op, is_hilo_op, op_signed, launch, mt_ok;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] div_tmp;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic        mul_done;

  always_comb begin
    is_md_op   = (mdop_q == OP_MULT) || (mdop_q == OP_MULTU) ||
                 (mdop_q == OP_DIV)  || (mdop_q == OP_DIVU);
    is_hilo_op = is_md_op || (mdop_q == OP_MFHI) || (mdop_q == OP_MFLO) ||
                 (mdop_q == OP_MTHI) || (mdop_q == OP_MTLO);
    op_signed  = (mdop_q == OP_MULT) || (mdop_q == OP_DIV);
    launch     = (state_q == ST_IDLE) && is_md_op && !bus.CLMI_RHOLD;
    mt_ok      = (state_q == ST_IDLE) && !bus.CLMI_RHOLD;

    a_neg = op_signed && bus.REGA_E_R[31];
    b_neg = op_signed && bus.REGB_E_R[31];
    abs_a = a_neg ? (~bus.REGA_E_R + 32'd1) : bus.REGA_E_R;
    abs_b = b_neg ? (~bus.REGB_E_R + 32'd1) : bus.REGB_E_R;

    // Restoring step: partial remainder shifted left with the next dividend bit.
    // When it is >= divisor the true difference is < divisor, so 32 bits suffice.
    div_tmp = {acc_q[63:32], acc_q[31]};
    div_ge  = (div_tmp >= {1'b0, opb_q});
    div_sub = div_tmp[31:0] - opb_q;

    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

`ifdef DMULDIV_EARLY_TERM_EN
    mul_done = (cnt_q == CNT_LAST) || (opb_q[31:1] == 31'd0);
`else
    mul_done = (cnt_q == CNT_LAST);
`endif
  end

  always_comb begin
    mdop_d    = bus.CLMI_RHOLD ? mdop_q : bus.MDOP_E_P;
    ce0_sel_d = (mdop_d == OP_MFHI) || (mdop_d == OP_MFLO);
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          is_div_d  = (mdop_q == OP_DIV) || (mdop_q == OP_DIVU);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          opb_d     = abs_b;
          cnt_d     = '0;
          if (is_div_d) begin
            acc_d   = {32'd0, abs_a};
            state_d = ST_DIV;
          end else begin
            acc_d   = 64'd0;
            mcand_d = {32'd0, abs_a};
            state_d = ST_MUL;
          end
        end else if (mt_ok && (mdop_q == OP_MTHI)) begin
          hi_d = bus.REGA_E_R;
        end else if (mt_ok && (mdop_q == OP_MTLO)) begin
          lo_d = bus.REGA_E_R;
        end
      end
      ST_MUL: begin
        if (opb_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[62:0], 1'b0};
        opb_d   = {1'b0, opb_q[31:1]};
        cnt_d   = cnt_q + MD_CNTW'(1);
        if (mul_done) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (div_ge) acc_d = {div_sub, acc_q[30:0], 1'b1};
        else        acc_d = {div_tmp[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + MD_CNTW'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          // Divide by zero: the algorithm already leaves |A| in the remainder,
          // and restoring the dividend sign yields the raw A for HI.
          lo_d = (opb_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RESET_D2_R) begin
    if (RESET_D2_R) begin
      state_q   <= ST_IDLE;
      mdop_q    <= OP_NOP;
      ce0_sel_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= 64'd0;
      mcand_q   <= 64'd0;
      opb_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      mdop_q    <= mdop_d;
      ce0_sel_q <= ce0_sel_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.CE0_SEL_E_R = ce0_sel_q;
  assign bus.CE0_RES_E   = (mdop_q == OP_MFHI) ? hi_q :
                           (mdop_q == OP_MFLO) ? lo_q : 32'd0;
  assign bus.MD_BUSY     = (state_q != ST_IDLE);
  assign bus.MD_STALL_E  = is_hilo_op && (state_q != ST_IDLE);

`ifndef SYNTHESIS
  a_legal_op: assert property (@(posedge SYSCLK) disable iff (RESET_D2_R)
    mdop_q <= OP_MTLO);
  a_no_idle_stall: assert property (@(posedge SYSCLK) disable iff (RESET_D2_R)
    !(bus.MD_STALL_E && (state_q == ST_IDLE)));
`endif

endmodule

// File: tb/tb_dmuldiv.sv
// tb_dmuldiv
//   Directed vectors for dmuldiv. MFHI/MFLO expectations go into a scoreboard
//   queue; a monitor pops one entry whenever CE0 presents an unstalled result.
//   Latency/stall/reset checks are made inline by the stimulus process.
module tb_dmuldiv;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

`ifdef DMULDIV_EARLY_TERM_EN
  localparam int EXP_ET_BUSY = 3;
`else
  localparam int EXP_ET_BUSY = 33;
`endif

  logic        clk;
  logic        rst;
  logic        ext_hold;
  logic [31:0] rega_p, regb_p, rega_e, regb_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  dmuldiv_if bus ();

  dmuldiv dut (
    .SYSCLK     (clk),
    .RESET_D2_R (rst),
    .bus        (bus)
  );

  assign bus.CLMI_RHOLD = ext_hold | bus.MD_STALL_E;
  assign bus.REGA_E_R   = rega_e;
  assign bus.REGB_E_R   = regb_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // E-stage operand registers travel with the op code.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rega_e <= 32'd0;
      regb_e <= 32'd0;
    end else if (!bus.CLMI_RHOLD) begin
      rega_e <= rega_p;
      regb_e <= regb_p;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.CE0_SEL_E_R && !bus.MD_STALL_E) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ce0: got %h want no result", bus.CE0_RES_E);
      end else begin
        logic [31:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, bus.CE0_RES_E, e);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    @(negedge clk);
    bus.MDOP_E_P = op;
    rega_p = a;
    regb_p = b;
    while (bus.CLMI_RHOLD && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got hold stuck want accept of op %0d", op);
    end
    @(posedge clk);
    #1 bus.MDOP_E_P = OP_NOP;
  endtask

  task automatic mf(input logic [3:0] op, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    issue(op, 32'd0, 32'd0);
  endtask

  // Counts negedges during which busy (or stall) is high; optionally pulses
  // an unrelated pipeline hold partway through.
  task automatic measure(input bit use_stall, input int hold_at, output int n);
    int g;
    g = 0;
    n = 0;
    @(negedge clk);
    while (!(use_stall ? bus.MD_STALL_E : bus.MD_BUSY) && g < 4) begin
      @(negedge clk);
      g++;
    end
    while ((use_stall ? bus.MD_STALL_E : bus.MD_BUSY) && n < 200) begin
      n++;
      if (hold_at > 0 && n == hold_at)     ext_hold = 1'b1;
      if (hold_at > 0 && n == hold_at + 5) ext_hold = 1'b0;
      @(negedge clk);
    end
    ext_hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g;
    rst          = 1'b1;
    ext_hold     = 1'b0;
    bus.MDOP_E_P = OP_NOP;
    rega_p       = 32'd0;
    regb_p       = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",  {31'd0, bus.MD_BUSY},     32'd0);
    chk("reset_stall", {31'd0, bus.MD_STALL_E},  32'd0);
    chk("reset_sel",   {31'd0, bus.CE0_SEL_E_R}, 32'd0);
    chk("reset_res",   bus.CE0_RES_E,            32'd0);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    measure(1'b0, 0, n);
    mf(OP_MFHI, 32'hFFFF_FFFF, "mult_hi");
    mf(OP_MFLO, 32'hFFFF_FFFA, "mult_lo");

    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    measure(1'b0, 0, n);
    mf(OP_MFHI, 32'h0000_0002, "multu_hi");
    mf(OP_MFLO, 32'hFFFF_FFFA, "multu_lo");

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    measure(1'b0, 0, n);
    chk("div_busy_len", n, 32'd33);
    mf(OP_MFLO, 32'hFFFF_FFFD, "div_lo");
    mf(OP_MFHI, 32'hFFFF_FFFF, "div_hi");

    issue(OP_DIVU, 32'd100, 32'd7);
    measure(1'b0, 5, n);
    chk("divu_hold_busy_len", n, 32'd33);
    mf(OP_MFLO, 32'd14, "divu_lo");
    mf(OP_MFHI, 32'd2,  "divu_hi");

    issue(OP_DIV, 32'h0000_1234, 32'd0);
    measure(1'b0, 0, n);
    mf(OP_MFLO, 32'hFFFF_FFFF, "div0_lo");
    mf(OP_MFHI, 32'h0000_1234, "div0_hi");

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    measure(1'b0, 0, n);
    mf(OP_MFLO, 32'h8000_0000, "divovf_lo");
    mf(OP_MFHI, 32'h0000_0000, "divovf_hi");

    issue(OP_MULTU, 32'd3, 32'h8000_0001);
    mf(OP_MFLO, 32'h8000_0003, "mflo_stalled_lo");
    measure(1'b1, 0, n);
    chk("mflo_stall_len", n, 32'd33);
    chk("mflo_sel_after", {31'd0, bus.CE0_SEL_E_R}, 32'd1);

    issue(OP_MULTU, 32'd3, 32'h8000_0001);
    issue(OP_MTHI, 32'hCAFE_BABE, 32'd0);
    measure(1'b1, 0, n);
    chk("mthi_stall_len", n, 32'd33);
    mf(OP_MFHI, 32'hCAFE_BABE, "mthi_hi");
    mf(OP_MFLO, 32'h8000_0003, "mthi_lo_kept");

    issue(OP_MTLO, 32'h0000_55AA, 32'd0);
    mf(OP_MFLO, 32'h0000_55AA, "mtlo_lo");
    chk("mf_idle_nostall", {31'd0, bus.MD_STALL_E}, 32'd0);

    issue(OP_MULTU, 32'd5, 32'd3);
    measure(1'b0, 0, n);
    chk("multu_5x3_busy_len", n, 32'(EXP_ET_BUSY));
    mf(OP_MFLO, 32'd15, "multu_5x3_lo");

    issue(OP_DIVU, 32'd1000, 32'd3);
    g = 0;
    @(negedge clk);
    while (!bus.MD_BUSY && g < 4) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    chk("rst_pre_busy", {31'd0, bus.MD_BUSY}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy",  {31'd0, bus.MD_BUSY},    32'd0);
    chk("rst_mid_stall", {31'd0, bus.MD_STALL_E}, 32'd0);
    chk("rst_mid_res",   bus.CE0_RES_E,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    mf(OP_MFHI, 32'd0, "rst_hi");
    chk("rst_mfhi_nostall", {31'd0, bus.MD_STALL_E}, 32'd0);
    mf(OP_MFLO, 32'd0, "rst_lo");

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
